// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: synchronised input, 3-sample majority voting,
// optional parity, 1/2 stop bits, parity/framing error flags and break detection.
module uart_rx_frame #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [31:0]          clocksPerBit,
    input  logic [1:0]           parityMode,
    input  logic                 rxData,
    output logic                 rxDv,
    output logic [DATA_BITS-1:0] rxByte,
    output logic                 parityErr,
    output logic                 frameErr,
    output logic                 breakDet,
    output logic                 busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rx_s;

    logic [2:0]           state_q, state_d;
    logic [31:0]          cpb_q, cpb_d;
    logic                 par_en_q, par_en_d;
    logic                 odd_q, odd_d;
    logic [31:0]          clk_cnt_q, clk_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 s0_q, s0_d;
    logic                 s1_q, s1_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_mis_q, par_mis_d;
    logic                 stop_err_q, stop_err_d;
    logic                 seen_one_q, seen_one_d;
    logic                 rx_dv_q, rx_dv_d;
    logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
    logic                 par_err_q, par_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 break_q, break_d;

    logic [31:0] mid;
    logic        at_lo, at_mid, at_res, at_end;
    logic        vote;
    logic [31:0] cnt_next;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign mid      = (cpb_q - 32'd1) >> 1;
    assign at_lo    = (clk_cnt_q == mid - 32'd1);
    assign at_mid   = (clk_cnt_q == mid);
    assign at_res   = (clk_cnt_q == mid + 32'd1);
    assign at_end   = (clk_cnt_q == cpb_q - 32'd1);
    // Third sample is the live line, so the bit resolves combinationally at mid+1.
    assign vote     = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
    assign cnt_next = at_end ? '0 : clk_cnt_q + 32'd1;

    always_comb begin
        state_d     = state_q;
        cpb_d       = cpb_q;
        par_en_d    = par_en_q;
        odd_d       = odd_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        s0_d        = at_lo  ? rx_s : s0_q;
        s1_d        = at_mid ? rx_s : s1_q;
        shift_d     = shift_q;
        par_mis_d   = par_mis_q;
        stop_err_d  = stop_err_q;
        seen_one_d  = seen_one_q;
        rx_dv_d     = 1'b0;
        rx_byte_d   = rx_byte_q;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;
        break_d     = break_q;

        case (state_q)
            IDLE: begin
                if (!rx_s && prev_q) begin
                    state_d    = START;
                    cpb_d      = (clocksPerBit < 32'd4) ? 32'd4 : clocksPerBit;
                    par_en_d   = (parityMode == 2'b01) || (parityMode == 2'b10);
                    odd_d      = (parityMode == 2'b01);
                    clk_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    par_mis_d  = 1'b0;
                    stop_err_d = 1'b0;
                    seen_one_d = 1'b0;
                end
            end
            START: begin
                clk_cnt_d = cnt_next;
                if (at_res && vote) begin
                    state_d   = IDLE;
                    clk_cnt_d = '0;
                end else if (at_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                clk_cnt_d = cnt_next;
                if (at_res) begin
                    // Shifting in from the MSB leaves the first (LSB) bit at index 0.
                    shift_d    = {vote, shift_q[DATA_BITS-1:1]};
                    seen_one_d = seen_one_q | vote;
                end
                if (at_end) begin
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                clk_cnt_d = cnt_next;
                if (at_res) begin
                    par_mis_d  = vote != ((^shift_q) ^ odd_q);
                    seen_one_d = seen_one_q | vote;
                end
                if (at_end) state_d = STOP;
            end
            STOP: begin
                clk_cnt_d = cnt_next;
                if (at_res) begin
                    if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                        state_d     = IDLE;
                        clk_cnt_d   = '0;
                        bit_cnt_d   = '0;
                        rx_dv_d     = 1'b1;
                        rx_byte_d   = shift_q;
                        par_err_d   = par_en_q & par_mis_q;
                        frame_err_d = stop_err_q | ~vote;
                        break_d     = ~(seen_one_q | vote);
                    end else begin
                        stop_err_d = stop_err_q | ~vote;
                        seen_one_d = seen_one_q | vote;
                    end
                end else if (at_end) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync_q      <= '1;
            prev_q      <= 1'b1;
            state_q     <= IDLE;
            cpb_q       <= '0;
            par_en_q    <= 1'b0;
            odd_q       <= 1'b0;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            s0_q        <= 1'b0;
            s1_q        <= 1'b0;
            shift_q     <= '0;
            par_mis_q   <= 1'b0;
            stop_err_q  <= 1'b0;
            seen_one_q  <= 1'b0;
            rx_dv_q     <= 1'b0;
            rx_byte_q   <= '0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            break_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], rxData};
            prev_q      <= rx_s;
            state_q     <= state_d;
            cpb_q       <= cpb_d;
            par_en_q    <= par_en_d;
            odd_q       <= odd_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            shift_q     <= shift_d;
            par_mis_q   <= par_mis_d;
            stop_err_q  <= stop_err_d;
            seen_one_q  <= seen_one_d;
            rx_dv_q     <= rx_dv_d;
            rx_byte_q   <= rx_byte_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            break_q     <= break_d;
        end
    end

    assign rxDv      = rx_dv_q;
    assign rxByte    = rx_byte_q;
    assign parityErr = par_err_q;
    assign frameErr  = frame_err_q;
    assign breakDet  = break_q;
    // Completion cycle already sits in IDLE, so busy stretches over the rxDv pulse.
    assign busy      = (state_q != IDLE) | rx_dv_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed and randomised frames on an 8N1-default
// instance and a 7-data/2-stop instance, checked against a frame-level model.
module tb_uart_rx_frame;

    typedef struct {
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       bd;
        logic       busy;
    } rec_t;

    logic        clk = 1'b0;
    logic        resetN;
    logic [31:0] cpb8, cpb7;
    logic [1:0]  mode8, mode7;
    logic        rx8, rx7;
    logic        dv8, pe8, fe8, bd8, busy8;
    logic        dv7, pe7, fe7, bd7, busy7;
    logic [7:0]  byte8;
    logic [6:0]  byte7;

    int nvec = 0;
    int nerr = 0;
    rec_t q8[$];
    rec_t q7[$];

    always #5 clk = ~clk;

    uart_rx_frame dut8 (
        .clk(clk), .resetN(resetN), .clocksPerBit(cpb8), .parityMode(mode8),
        .rxData(rx8), .rxDv(dv8), .rxByte(byte8), .parityErr(pe8),
        .frameErr(fe8), .breakDet(bd8), .busy(busy8)
    );

    uart_rx_frame #(.DATA_BITS(7), .STOP_BITS(2), .SYNC_STAGES(2)) dut7 (
        .clk(clk), .resetN(resetN), .clocksPerBit(cpb7), .parityMode(mode7),
        .rxData(rx7), .rxDv(dv7), .rxByte(byte7), .parityErr(pe7),
        .frameErr(fe7), .breakDet(bd7), .busy(busy7)
    );

    always @(negedge clk) begin
        if (dv8) q8.push_back('{data: {1'b0, byte8}, pe: pe8, fe: fe8, bd: bd8, busy: busy8});
        if (dv7) q7.push_back('{data: {2'b00, byte7}, pe: pe7, fe: fe7, bd: bd7, busy: busy7});
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int which, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (which == 8) rx8 = 1'b1;
            else            rx7 = 1'b1;
        end
    endtask

    // Drives bits[k/cpb] for 'limit' cycles; scrambles the config inputs once the frame is latched.
    task automatic send_line(input int which, input logic [15:0] bits, input int cpb,
                             input int glitch, input int limit);
        logic v;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            v = bits[k / cpb];
            if (k == glitch) v = ~v;
            if (k == 4) begin
                if (which == 8) begin cpb8 = $urandom; mode8 = 2'($urandom); end
                else            begin cpb7 = $urandom; mode7 = 2'($urandom); end
            end
            if (which == 8) rx8 = v;
            else            rx7 = v;
        end
    endtask

    task automatic run_frame(input int which, input logic [8:0] data, input logic [31:0] cpb_in,
                             input logic [1:0] mode, input logic pbit, input logic [1:0] stops,
                             input int glitch, input string tag);
        int db, nstop, n, cpb, ones, sz;
        logic [15:0] bits;
        logic [8:0]  e_data;
        logic par_en, exp_pbit, e_pe, e_fe, e_bd, busy_now;
        rec_t r;

        db     = (which == 8) ? 8 : 7;
        nstop  = (which == 8) ? 1 : 2;
        cpb    = (cpb_in < 32'd4) ? 4 : int'(cpb_in);
        par_en = (mode == 2'b01) || (mode == 2'b10);
        e_data = data & 9'((1 << db) - 1);
        ones   = $countones(e_data);
        exp_pbit = ((ones % 2) == 1) ^ (mode == 2'b01);
        e_pe   = par_en && (pbit != exp_pbit);
        e_fe   = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
        e_bd   = (e_data == 9'd0) && (!par_en || !pbit) && (stops[0] == 1'b0)
                 && (nstop == 1 || stops[1] == 1'b0);

        bits = '1;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < db; i++) begin bits[n] = e_data[i]; n++; end
        if (par_en) begin bits[n] = pbit; n++; end
        for (int s = 0; s < nstop; s++) begin bits[n] = stops[s]; n++; end

        if (which == 8) begin cpb8 = cpb_in; mode8 = mode; end
        else            begin cpb7 = cpb_in; mode7 = mode; end
        send_line(which, bits, cpb, glitch, n * cpb);
        idle(which, cpb + 8);

        if (which == 8) begin sz = q8.size(); if (sz > 0) r = q8[0]; q8.delete(); busy_now = busy8; end
        else            begin sz = q7.size(); if (sz > 0) r = q7[0]; q7.delete(); busy_now = busy7; end

        chk({tag, ".dv_count"}, sz, 1);
        if (sz > 0) begin
            chk({tag, ".rxByte"}, r.data, e_data);
            chk({tag, ".parityErr"}, r.pe, e_pe);
            chk({tag, ".frameErr"}, r.fe, e_fe);
            chk({tag, ".breakDet"}, r.bd, e_bd);
            chk({tag, ".busy_at_dv"}, r.busy, 1);
        end
        chk({tag, ".busy_after"}, busy_now, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".rxDv8"}, dv8, 0);
        chk({tag, ".rxByte8"}, byte8, 0);
        chk({tag, ".parityErr8"}, pe8, 0);
        chk({tag, ".frameErr8"}, fe8, 0);
        chk({tag, ".breakDet8"}, bd8, 0);
        chk({tag, ".busy8"}, busy8, 0);
        chk({tag, ".rxDv7"}, dv7, 0);
        chk({tag, ".rxByte7"}, byte7, 0);
        chk({tag, ".parityErr7"}, pe7, 0);
        chk({tag, ".frameErr7"}, fe7, 0);
        chk({tag, ".breakDet7"}, bd7, 0);
        chk({tag, ".busy7"}, busy7, 0);
    endtask

    initial begin
        logic [15:0] fbits;
        logic        seen_busy;
        logic [7:0]  rd;
        logic [1:0]  st;

        resetN = 1'b0;
        rx8 = 1'b1; rx7 = 1'b1;
        cpb8 = 32'd16; cpb7 = 32'd10;
        mode8 = 2'b00; mode7 = 2'b00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        resetN = 1'b1;
        idle(8, 10);

        run_frame(8, 9'h0A5, 32'd16, 2'b00, 1'b0, 2'b11, -1, "8n1_a5");
        run_frame(8, 9'h003, 32'd16, 2'b10, 1'b1, 2'b11, -1, "even_p1");
        run_frame(8, 9'h003, 32'd16, 2'b10, 1'b0, 2'b11, -1, "even_p0");
        run_frame(8, 9'h003, 32'd16, 2'b01, 1'b1, 2'b11, -1, "odd_p1");

        // Three-cycle low pulse in IDLE: false start, abandoned at count mid+1.
        cpb8 = 32'd16; mode8 = 2'b00;
        for (int k = 0; k < 3; k++) begin @(negedge clk); rx8 = 1'b0; end
        @(negedge clk); rx8 = 1'b1;
        seen_busy = 1'b0;
        for (int k = 4; k < 14; k++) begin
            @(negedge clk);
            if (busy8) seen_busy = 1'b1;
        end
        @(negedge clk);
        chk("false_start.busy_rose", seen_busy, 1);
        chk("false_start.busy_fell", busy8, 0);
        idle(8, 60);
        chk("false_start.no_dv", q8.size(), 0);

        run_frame(8, 9'h0FF, 32'd16, 2'b00, 1'b0, 2'b11, 3 * 16 + 7, "glitch_ff");
        run_frame(7, 9'h055, 32'd10, 2'b00, 1'b0, 2'b01, -1, "d7_stop2_low");
        run_frame(8, 9'h05A, 32'd2, 2'b00, 1'b0, 2'b11, -1, "cpb_clamp");

        // Long break: one error frame, then silence until the line returns high.
        cpb8 = 32'd16; mode8 = 2'b00;
        for (int k = 0; k < 20 * 16; k++) begin @(negedge clk); rx8 = 1'b0; end
        idle(8, 40);
        chk("break.dv_count", q8.size(), 1);
        if (q8.size() > 0) begin
            chk("break.rxByte", q8[0].data, 0);
            chk("break.frameErr", q8[0].fe, 1);
            chk("break.breakDet", q8[0].bd, 1);
            chk("break.parityErr", q8[0].pe, 0);
        end
        q8.delete();
        run_frame(8, 9'h03C, 32'd16, 2'b00, 1'b0, 2'b11, -1, "after_break");

        // Reset in the middle of data bit 4 of 0x81.
        cpb8 = 32'd16; mode8 = 2'b00;
        fbits = 16'hFFFF;
        fbits[0] = 1'b0;
        rd = 8'h81;
        for (int i = 0; i < 8; i++) fbits[1 + i] = rd[i];
        send_line(8, fbits, 16, -1, 5 * 16 + 8);
        @(negedge clk);
        resetN = 1'b0;
        rx8 = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        idle(8, 40);
        chk("mid_reset.no_dv", q8.size(), 0);
        run_frame(8, 9'h081, 32'd16, 2'b00, 1'b0, 2'b11, -1, "after_reset");

        for (int i = 0; i < 14; i++) begin
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            run_frame(8, 9'($urandom), $urandom_range(0, 20), 2'($urandom), 1'($urandom), st,
                      (i % 2 == 0) ? -1 : int'($urandom_range(16, 40)), "rnd8");
        end
        for (int i = 0; i < 8; i++) begin
            st = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11;
            run_frame(7, 9'($urandom), $urandom_range(0, 16), 2'($urandom), 1'($urandom), st,
                      -1, "rnd7");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
